// File: rtl/rank_unsort.sv
// rank_unsort: sequential inverse of the rank sorter.
// A captured key vector is ranked one compare per cycle (N*N cycles) using a
// stable tie-break, so the ranks always form a permutation. The held
// permutation then scatters each sorted-domain vector back to original order:
// rdata_out[i] = sdata_in[rank[i]].
module rank_unsort #(
    parameter  int N     = 6,
    parameter  int WIDTH = 8,
    localparam int RW    = $clog2(N)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      key_valid,
    output logic                      key_ready,
    input  logic [N-1:0][WIDTH-1:0]   key_in,
    output logic                      rank_valid,
    output logic [N-1:0][RW-1:0]      rank_out,
    input  logic                      sdata_valid,
    output logic                      sdata_ready,
    input  logic [N-1:0][WIDTH-1:0]   sdata_in,
    output logic                      rdata_valid,
    input  logic                      rdata_ready,
    output logic [N-1:0][WIDTH-1:0]   rdata_out
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RANK     = 3'd1,
        S_ARMED    = 3'd2,
        S_OUT      = 3'd3,
        S_OUT_PEND = 3'd4
    } state_t;

    localparam logic [RW-1:0] LAST_IDX = RW'(N - 1);

    state_t                    r_state;
    state_t                    w_state_next;

    logic [N-1:0][WIDTH-1:0]   r_key;
    logic [N-1:0][RW-1:0]      r_acc;
    logic [RW-1:0]             r_i;
    logic [RW-1:0]             r_j;
    logic [N-1:0][RW-1:0]      r_rank_out;
    logic                      r_rank_valid;
    logic                      r_key_ready;
    logic                      r_sdata_ready;
    logic                      r_rdata_valid;
    logic [N-1:0][WIDTH-1:0]   r_rdata_out;

    logic                      w_key_xfer;
    logic                      w_sdata_xfer;
    logic                      w_rdata_xfer;
    logic                      w_last_j;
    logic                      w_last_cmp;
    logic [WIDTH-1:0]          w_key_i;
    logic [WIDTH-1:0]          w_key_j;
    logic                      w_inc;
    logic [N-1:0][RW-1:0]      w_acc_next;
    logic [N-1:0][WIDTH-1:0]   w_restored;

    assign key_ready   = r_key_ready;
    assign sdata_ready = r_sdata_ready;
    assign rdata_valid = r_rdata_valid;
    assign rank_valid  = r_rank_valid;
    assign rank_out    = r_rank_out;
    assign rdata_out   = r_rdata_out;

    assign w_key_xfer   = key_valid & r_key_ready;
    assign w_sdata_xfer = sdata_valid & r_sdata_ready;
    assign w_rdata_xfer = r_rdata_valid & rdata_ready;
    assign w_last_j     = (r_j == LAST_IDX);
    assign w_last_cmp   = w_last_j & (r_i == LAST_IDX);

    // Single compare per cycle: does key[j] sort strictly before key[i]?
    always_comb begin
        w_key_i = r_key[r_i];
        w_key_j = r_key[r_j];
        if (w_key_j < w_key_i) begin
            w_inc = 1'b1;
        end else if ((w_key_j == w_key_i) && (r_j < r_i)) begin
            w_inc = 1'b1;
        end else begin
            w_inc = 1'b0;
        end
    end

    // Accumulator update: only element i can gain a rank this cycle.
    always_comb begin
        w_acc_next = r_acc;
        for (int k = 0; k < N; k++) begin
            if ((RW'(k) == r_i) && w_inc) begin
                w_acc_next[k] = r_acc[k] + RW'(1'b1);
            end else begin
                w_acc_next[k] = r_acc[k];
            end
        end
    end

    // Scatter the sorted-domain vector back to original element order.
    always_comb begin
        w_restored = '0;
        for (int k = 0; k < N; k++) begin
            w_restored[k] = sdata_in[r_rank_out[k]];
        end
    end

    // Next-state logic for the capture/rank/restore sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_key_xfer) begin
                    w_state_next = S_RANK;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RANK: begin
                if (w_last_cmp) begin
                    w_state_next = S_ARMED;
                end else begin
                    w_state_next = S_RANK;
                end
            end
            S_ARMED: begin
                // A simultaneous key load must wait behind the restore it
                // raced with, since both producers already saw ready.
                if (w_sdata_xfer && w_key_xfer) begin
                    w_state_next = S_OUT_PEND;
                end else if (w_sdata_xfer) begin
                    w_state_next = S_OUT;
                end else if (w_key_xfer) begin
                    w_state_next = S_RANK;
                end else begin
                    w_state_next = S_ARMED;
                end
            end
            S_OUT: begin
                if (w_rdata_xfer) begin
                    w_state_next = S_ARMED;
                end else begin
                    w_state_next = S_OUT;
                end
            end
            S_OUT_PEND: begin
                if (w_rdata_xfer) begin
                    w_state_next = S_RANK;
                end else begin
                    w_state_next = S_OUT_PEND;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Registered handshake/status outputs, derived from the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key_ready   <= 1'b1;
            r_sdata_ready <= 1'b0;
            r_rdata_valid <= 1'b0;
            r_rank_valid  <= 1'b0;
        end else begin
            r_key_ready   <= (w_state_next == S_IDLE) || (w_state_next == S_ARMED);
            r_sdata_ready <= (w_state_next == S_ARMED);
            r_rdata_valid <= (w_state_next == S_OUT) || (w_state_next == S_OUT_PEND);
            // Ranks are valid only while the held permutation matches the
            // most recently accepted key vector.
            r_rank_valid  <= (w_state_next == S_ARMED) || (w_state_next == S_OUT);
        end
    end

    // Datapath: key capture, rank accumulation, permutation and restore.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_key       <= '0;
            r_acc       <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_rank_out  <= '0;
            r_rdata_out <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_key_xfer) begin
                        r_key <= key_in;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                S_RANK: begin
                    r_acc <= w_acc_next;
                    if (w_last_cmp) begin
                        r_i        <= '0;
                        r_j        <= '0;
                        r_rank_out <= w_acc_next;
                    end else if (w_last_j) begin
                        r_i <= r_i + RW'(1'b1);
                        r_j <= '0;
                    end else begin
                        r_j <= r_j + RW'(1'b1);
                    end
                end
                S_ARMED: begin
                    if (w_sdata_xfer) begin
                        r_rdata_out <= w_restored;
                    end
                    if (w_key_xfer) begin
                        r_key <= key_in;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                S_OUT: begin
                    r_rdata_out <= r_rdata_out;
                end
                S_OUT_PEND: begin
                    // Keys were latched on entry; restart the scan cleanly.
                    if (w_rdata_xfer) begin
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                default: begin
                    r_acc <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rank_unsort.sv
// Self-checking bench for rank_unsort: directed scenarios plus random vectors
// against a stable-sort reference model.
module tb_rank_unsort;

    localparam int N  = 6;
    localparam int W  = 8;
    localparam int RW = 3;

    typedef logic [N-1:0][W-1:0]  vec_t;
    typedef logic [N-1:0][RW-1:0] rvec_t;

    logic  clk;
    logic  rst;
    logic  key_valid;
    logic  key_ready;
    vec_t  key_in;
    logic  rank_valid;
    rvec_t rank_out;
    logic  sdata_valid;
    logic  sdata_ready;
    vec_t  sdata_in;
    logic  rdata_valid;
    logic  rdata_ready;
    vec_t  rdata_out;

    int checks = 0;
    int errors = 0;

    rank_unsort #(.N(N), .WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .key_valid(key_valid), .key_ready(key_ready), .key_in(key_in),
        .rank_valid(rank_valid), .rank_out(rank_out),
        .sdata_valid(sdata_valid), .sdata_ready(sdata_ready), .sdata_in(sdata_in),
        .rdata_valid(rdata_valid), .rdata_ready(rdata_ready), .rdata_out(rdata_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input int a0, input int a1, input int a2,
                                input int a3, input int a4, input int a5);
        vec_t v;
        v[0] = a0[W-1:0]; v[1] = a1[W-1:0]; v[2] = a2[W-1:0];
        v[3] = a3[W-1:0]; v[4] = a4[W-1:0]; v[5] = a5[W-1:0];
        return v;
    endfunction

    function automatic rvec_t mkr(input int a0, input int a1, input int a2,
                                  input int a3, input int a4, input int a5);
        rvec_t v;
        v[0] = a0[RW-1:0]; v[1] = a1[RW-1:0]; v[2] = a2[RW-1:0];
        v[3] = a3[RW-1:0]; v[4] = a4[RW-1:0]; v[5] = a5[RW-1:0];
        return v;
    endfunction

    // Reference: stable insertion sort of indices; rank = sorted position.
    function automatic rvec_t model_rank(input vec_t k);
        int    idx[N];
        rvec_t r;
        for (int i = 0; i < N; i++) idx[i] = i;
        for (int i = 1; i < N; i++) begin
            int t = idx[i];
            int p = i;
            while (p > 0 && k[idx[p-1]] > k[t]) begin
                idx[p] = idx[p-1];
                p--;
            end
            idx[p] = t;
        end
        for (int p = 0; p < N; p++) r[idx[p]] = p[RW-1:0];
        return r;
    endfunction

    function automatic vec_t model_restore(input vec_t s, input rvec_t r);
        vec_t o;
        for (int i = 0; i < N; i++) o[i] = s[r[i]];
        return o;
    endfunction

    function automatic vec_t rand_vec(input int maxv);
        vec_t v;
        for (int i = 0; i < N; i++) v[i] = W'($urandom_range(0, maxv));
        return v;
    endfunction

    task automatic do_reset();
        rst = 1'b1; key_valid = 1'b0; sdata_valid = 1'b0; rdata_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the key transfer edge.
    task automatic send_key(input vec_t k);
        bit ok = 1'b0;
        key_in = k; key_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (key_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        key_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL key_handshake: got no transfer, required transfer within 100 cycles"); end
    endtask

    task automatic send_sdata(input vec_t s);
        bit ok = 1'b0;
        sdata_in = s; sdata_valid = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            if (sdata_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
            @(negedge clk);
        end
        sdata_valid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL sdata_handshake: got no transfer, required transfer within 100 cycles"); end
    endtask

    // Counts cycles from the transfer edge until rank_valid is seen.
    task automatic wait_rank(output int n);
        n = 0;
        while (rank_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic release_rdata();
        rdata_ready = 1'b1;
        @(negedge clk);
        rdata_ready = 1'b0;
    endtask

    task automatic rank_and_check(input vec_t k, input string tag);
        int    n;
        rvec_t exp = model_rank(k);
        send_key(k);
        wait_rank(n);
        checks++;
        if (n !== N*N) begin errors++; $display("FAIL %s_latency: got %0d required %0d", tag, n, N*N); end
        checks++;
        if (rank_out !== exp) begin errors++; $display("FAIL %s_rank: got %h required %h", tag, rank_out, exp); end
    endtask

    task automatic restore_and_check(input vec_t s, input string tag);
        vec_t exp = model_restore(s, model_rank(dut.r_key));
        send_sdata(s);
        checks++;
        if (rdata_valid !== 1'b1) begin errors++; $display("FAIL %s_rvalid: got %b required 1", tag, rdata_valid); end
        checks++;
        if (rdata_out !== exp) begin errors++; $display("FAIL %s_rdata: got %h required %h", tag, rdata_out, exp); end
        release_rdata();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (key_ready !== 1'b1)   begin errors++; $display("FAIL reset_key_ready: got %b required 1", key_ready); end
        checks++; if (rank_valid !== 1'b0)  begin errors++; $display("FAIL reset_rank_valid: got %b required 0", rank_valid); end
        checks++; if (sdata_ready !== 1'b0) begin errors++; $display("FAIL reset_sdata_ready: got %b required 0", sdata_ready); end
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL reset_rdata_valid: got %b required 0", rdata_valid); end
        checks++; if (rank_out !== '0)      begin errors++; $display("FAIL reset_rank_out: got %h required 0", rank_out); end
        checks++; if (rdata_out !== '0)     begin errors++; $display("FAIL reset_rdata_out: got %h required 0", rdata_out); end
    endtask

    task automatic test_distinct();
        int   n;
        vec_t exp_d = mk(3, 1, 5, 2, 4, 6);
        send_key(mk(30, 10, 50, 20, 40, 60));
        wait_rank(n);
        checks++; if (n !== 36) begin errors++; $display("FAIL distinct_latency: got %0d required 36", n); end
        checks++; if (rank_out !== mkr(2, 0, 4, 1, 3, 5)) begin errors++; $display("FAIL distinct_rank: got %h required %h", rank_out, mkr(2, 0, 4, 1, 3, 5)); end
        checks++; if (key_ready !== 1'b1 || sdata_ready !== 1'b1) begin errors++; $display("FAIL distinct_armed: got key_ready=%b sdata_ready=%b required 1/1", key_ready, sdata_ready); end
        send_sdata(mk(1, 2, 3, 4, 5, 6));
        checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL distinct_rvalid: got %b required 1", rdata_valid); end
        checks++; if (rdata_out !== exp_d) begin errors++; $display("FAIL distinct_rdata: got %h required %h", rdata_out, exp_d); end
        release_rdata();
    endtask

    task automatic test_ties();
        vec_t exp_d = mk(40, 50, 20, 60, 30, 10);
        rank_and_check(mk(7, 7, 3, 7, 3, 0), "ties");
        checks++; if (rank_out !== mkr(3, 4, 1, 5, 2, 0)) begin errors++; $display("FAIL ties_rank_const: got %h required %h", rank_out, mkr(3, 4, 1, 5, 2, 0)); end
        send_sdata(mk(10, 20, 30, 40, 50, 60));
        checks++; if (rdata_out !== exp_d) begin errors++; $display("FAIL ties_rdata: got %h required %h", rdata_out, exp_d); end
        release_rdata();
    endtask

    task automatic test_backpressure();
        vec_t s = rand_vec(255);
        vec_t exp = model_restore(s, mkr(3, 4, 1, 5, 2, 0));
        send_sdata(s);
        for (int c = 0; c < 5; c++) begin
            sdata_in = rand_vec(255);
            checks++; if (rdata_valid !== 1'b1 || rdata_out !== exp) begin errors++; $display("FAIL bp_hold: got v=%b d=%h required v=1 d=%h", rdata_valid, rdata_out, exp); end
            checks++; if (sdata_ready !== 1'b0 || key_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got sdata_ready=%b key_ready=%b required 0/0", sdata_ready, key_ready); end
            @(negedge clk);
        end
        release_rdata();
        checks++; if (rdata_valid !== 1'b0 || sdata_ready !== 1'b1) begin errors++; $display("FAIL bp_release: got v=%b sdata_ready=%b required 0/1", rdata_valid, sdata_ready); end
    endtask

    task automatic test_back_to_back();
        rvec_t r = mkr(3, 4, 1, 5, 2, 0);
        rdata_ready = 1'b1;
        for (int v = 0; v < 3; v++) begin
            vec_t s = rand_vec(255);
            sdata_in = s; sdata_valid = 1'b1;
            checks++; if (sdata_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready%0d: got %b required 1", v, sdata_ready); end
            @(posedge clk);
            @(negedge clk);
            sdata_valid = 1'b0;
            checks++; if (rdata_valid !== 1'b1 || rdata_out !== model_restore(s, r)) begin errors++; $display("FAIL b2b_rdata%0d: got v=%b d=%h required v=1 d=%h", v, rdata_valid, rdata_out, model_restore(s, r)); end
            @(negedge clk);
        end
        rdata_ready = 1'b0;
        checks++; if (rank_valid !== 1'b1 || rank_out !== r) begin errors++; $display("FAIL b2b_ranks_kept: got v=%b r=%h required v=1 r=%h", rank_valid, rank_out, r); end
    endtask

    task automatic test_simultaneous();
        int    n;
        rvec_t r_old = mkr(3, 4, 1, 5, 2, 0);
        vec_t  newk = rand_vec(15);
        vec_t  s = rand_vec(255);
        vec_t  exp = model_restore(s, r_old);
        checks++; if (key_ready !== 1'b1 || sdata_ready !== 1'b1) begin errors++; $display("FAIL sim_armed: got %b/%b required 1/1", key_ready, sdata_ready); end
        key_in = newk; key_valid = 1'b1; sdata_in = s; sdata_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        key_valid = 1'b0; sdata_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checks++; if (rdata_valid !== 1'b1 || rdata_out !== exp) begin errors++; $display("FAIL sim_rdata: got v=%b d=%h required v=1 d=%h", rdata_valid, rdata_out, exp); end
            checks++; if (rank_valid !== 1'b0 || key_ready !== 1'b0 || sdata_ready !== 1'b0) begin errors++; $display("FAIL sim_flags: got rv=%b kr=%b sr=%b required 0/0/0", rank_valid, key_ready, sdata_ready); end
            @(negedge clk);
        end
        release_rdata();
        checks++; if (rdata_valid !== 1'b0) begin errors++; $display("FAIL sim_rdone: got %b required 0", rdata_valid); end
        wait_rank(n);
        checks++; if (n !== 36) begin errors++; $display("FAIL sim_latency: got %0d required 36", n); end
        checks++; if (rank_out !== model_rank(newk)) begin errors++; $display("FAIL sim_rank: got %h required %h", rank_out, model_rank(newk)); end
    endtask

    task automatic test_reset_mid();
        send_key(rand_vec(255));
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (key_ready !== 1'b1 || rank_valid !== 1'b0 || rdata_valid !== 1'b0 || sdata_ready !== 1'b0) begin errors++; $display("FAIL rst_rank_flags: got kr=%b rv=%b dv=%b sr=%b required 1/0/0/0", key_ready, rank_valid, rdata_valid, sdata_ready); end
        checks++; if (rank_out !== '0) begin errors++; $display("FAIL rst_rank_out: got %h required 0", rank_out); end
        rank_and_check(rand_vec(255), "rst_fresh1");
        send_sdata(rand_vec(255));
        checks++; if (rdata_valid !== 1'b1) begin errors++; $display("FAIL rst_out_enter: got %b required 1", rdata_valid); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (key_ready !== 1'b1 || rank_valid !== 1'b0 || rdata_valid !== 1'b0 || sdata_ready !== 1'b0) begin errors++; $display("FAIL rst_out_flags: got kr=%b rv=%b dv=%b sr=%b required 1/0/0/0", key_ready, rank_valid, rdata_valid, sdata_ready); end
        checks++; if (rdata_out !== '0) begin errors++; $display("FAIL rst_out_rdata: got %h required 0", rdata_out); end
        rank_and_check(rand_vec(3), "rst_fresh2");
        restore_and_check(rand_vec(255), "rst_fresh2");
    endtask

    task automatic test_extremes();
        vec_t k;
        rank_and_check(mk(255, 255, 255, 255, 255, 255), "all_equal");
        checks++; if (rank_out !== mkr(0, 1, 2, 3, 4, 5)) begin errors++; $display("FAIL all_equal_const: got %h required %h", rank_out, mkr(0, 1, 2, 3, 4, 5)); end
        k = rand_vec(255);
        k[0] = 8'd0; k[1] = 8'd255;
        rank_and_check(k, "unsigned");
        checks++; if (!(rank_out[1] > rank_out[0])) begin errors++; $display("FAIL unsigned_order: got rank[1]=%0d rank[0]=%0d required rank[1]>rank[0]", rank_out[1], rank_out[0]); end
        restore_and_check(rand_vec(255), "unsigned");
    endtask

    task automatic test_random();
        for (int it = 0; it < 6; it++) begin
            rank_and_check(rand_vec((it % 2 == 0) ? 3 : 255), "random");
            restore_and_check(rand_vec(255), "random_a");
            restore_and_check(rand_vec(255), "random_b");
        end
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; sdata_valid = 1'b0; rdata_ready = 1'b0;
        key_in = '0; sdata_in = '0;
        @(negedge clk);
        test_reset();
        test_distinct();
        test_ties();
        test_backpressure();
        test_back_to_back();
        test_simultaneous();
        test_reset_mid();
        test_extremes();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rank_unsort.md
Name: rank_unsort

Overview:
- Sequential inverse of the team's combinational rank sorter.
- Captures a key vector, computes a stable unique rank for each element over N*N cycles, and holds that permutation.
- Each later sorted-domain vector is scattered back to the original element order of the captured keys.
- Sits downstream of the sorter so that results processed in sorted order return to the original positions.

Parameters:
N, 6, number of elements per vector (N >= 2)
WIDTH, 8, bits per key and per data element
RW, $clog2(N), rank/index width (derived, localparam)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
key_valid  input  1  key vector offered
key_ready  output  1  block accepts key vector
key_in  input  [WIDTH-1:0] x N  unsigned keys in original order
rank_valid  output  1  rank_out holds a complete permutation
rank_out  output  [RW-1:0] x N  rank of each original element (0 = smallest)
sdata_valid  input  1  sorted-domain vector offered
sdata_ready  output  1  block accepts sorted-domain vector
sdata_in  input  [WIDTH-1:0] x N  vector in ascending-rank order
rdata_valid  output  1  restored vector valid
rdata_ready  input  1  consumer accepts restored vector
rdata_out  output  [WIDTH-1:0] x N  restored vector, rdata_out[i] = sdata_in[rank[i]]

Behaviour:
- Reset (rst high at a clk edge):
  - State goes to IDLE.
  - key_ready=1; rank_valid=0; sdata_ready=0; rdata_valid=0.
  - rank_out, rdata_out and internal key and rank registers all clear to 0.
  - rst overrides any handshake in the same cycle. Reset mid-RANK or mid-OUT abandons the operation and drops rdata_valid immediately.
- Handshakes: a transfer occurs on a clk edge where valid&&ready. Producers hold valid and data until the transfer. Outputs are registered.
- States:
  - IDLE: key_ready=1. key transfer -> latch key_in, clear rank accumulators, i=j=0, rank_valid=0 -> RANK.
  - RANK: key_ready=0, sdata_ready=0. Exactly one compare per cycle.
    - rank[i] increments when key[j]<key[i], or when key[j]==key[i] and j<i. This is a stable tie-break and guarantees a permutation; the case j==i never increments.
    - j counts 0..N-1. On wrap, i increments.
    - After the compare with i=N-1 and j=N-1: rank_out <= ranks, rank_valid=1 -> ARMED.
    - RANK lasts exactly N*N cycles. rank_valid rises N*N cycles after the key-transfer edge.
  - ARMED: key_ready=1, sdata_ready=1.
    - sdata transfer -> rdata_out[i] <= sdata_in[rank[i]] for all i, rdata_valid=1 -> OUT.
    - key transfer -> start a new RANK as from IDLE; rank_valid drops the next cycle.
    - If both transfer in the same cycle: the sdata transfer completes and is restored with the old ranks. The key vector is also latched and state goes to OUT_PEND. Neither input is dropped, because both producers saw ready=1.
  - OUT: key_ready=0, sdata_ready=0. rdata_valid and rdata_out are held stable until rdata_ready. On the rdata transfer -> ARMED.
  - OUT_PEND: same as OUT, but the rdata transfer leads to RANK using the latched keys. rank_valid=0 from entry to OUT_PEND.
- Throughput: one restored vector per 2 cycles (ARMED -> OUT -> ARMED). Restore latency is 1 cycle from the sdata transfer edge to rdata_valid.
- rank_out stays stable while rank_valid=1. It is rewritten only at RANK completion.
- Arithmetic: keys compare as unsigned WIDTH-bit. Rank accumulators are RW bits and cannot overflow, because the maximum rank is N-1.

Test Plan:
- Distinct keys, N=6: key_in={30,10,50,20,40,60} -> rank_valid high exactly 36 cycles after the key transfer, rank_out={2,0,4,1,3,5}. Then sdata_in={1,2,3,4,5,6} -> next cycle rdata_valid=1, rdata_out={3,1,5,2,4,6}.
- Ties: key_in={7,7,3,7,3,0} -> rank_out={3,4,1,5,2,0}. sdata_in={10,20,30,40,50,60} -> rdata_out={40,50,20,60,30,10}.
- Backpressure and reuse: hold rdata_ready=0 for 5 cycles -> rdata_out stable and sdata_ready=0 throughout. Then send 3 back-to-back sdata vectors with the same ranks -> each correctly restored, one per 2 cycles.
- Simultaneous key and sdata in ARMED: sdata restored with the old ranks, rank_valid=0. After the rdata transfer, a new RANK runs and new ranks appear 36 cycles later.
- Reset mid-RANK (cycle 10) and mid-OUT: next cycle key_ready=1 and rank_valid=rdata_valid=sdata_ready=0. A fresh key load then produces correct ranks.
- Extremes: all keys equal {255 x6} -> rank_out={0,1,2,3,4,5}. Keys {0,255,...} check unsigned compare: 255 ranks above 0.
